// File: rtl/maze_pkg.sv
// maze_pkg: shared types and sizes for the depth-first maze solver
package maze_pkg;
    localparam int MAZE_DIM    = 16;
    localparam int COORD_W     = 4;
    localparam int STACK_DEPTH = 256;
    localparam int ENTRY_W     = 10;
    localparam int SP_W        = 8;
    typedef enum logic [2:0] {S_IDLE, S_CHKSTART, S_MARK, S_PROBE, S_POP, S_DONE, S_FAIL} state_t;
    typedef enum logic [1:0] {DIR_R, DIR_D, DIR_L, DIR_U} dir_t;
endpackage

// File: rtl/maze_stack.sv
// maze_stack: 256x10 LIFO of {x,y,dir}, synchronous push, combinational top-of-stack
// ports: clk, rst_n (async, resets sp only), clr/push/pop controls, wdata in, sp depth, top entry
import maze_pkg::*;
module maze_stack (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               clr,
    input  logic               push,
    input  logic               pop,
    input  logic [ENTRY_W-1:0] wdata,
    output logic [SP_W-1:0]    sp,
    output logic [ENTRY_W-1:0] top
);
    logic [ENTRY_W-1:0] mem [STACK_DEPTH];
    logic [SP_W-1:0] sp_q, sp_d;
    always_comb sp_d = clr ? '0 : push ? sp_q + 1'b1 : pop ? sp_q - 1'b1 : sp_q;
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) sp_q <= '0;
        else        sp_q <= sp_d;
    always_ff @(posedge clk)
        if (push) mem[sp_q] <= wdata;
    assign sp  = sp_q;
    assign top = mem[sp_q - 1'b1];
endmodule

// File: rtl/maze_solver.sv
// maze_solver: depth-first search from start to goal over a 16x16 bit-per-cell maze memory
// ports: clk, rst_n (async active-low), start pulse, Dout cell read data;
//        X/Y cell address, RD/WR strobes, Din write data, busy/done/fail status, path_len = stack depth
import maze_pkg::*;
module maze_solver #(
    parameter int START_X = 0,
    parameter int START_Y = 0,
    parameter int GOAL_X  = 15,
    parameter int GOAL_Y  = 15
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       Dout,
    output logic [3:0] X,
    output logic [3:0] Y,
    output logic       RD,
    output logic       WR,
    output logic       Din,
    output logic       busy,
    output logic       done,
    output logic       fail,
    output logic [7:0] path_len
);
    localparam logic [COORD_W-1:0] CMAX = COORD_W'(MAZE_DIM - 1);
    state_t state_q, state_d;
    logic [COORD_W-1:0] cx_q, cx_d, cy_q, cy_d, nx, ny;
    logic [2:0] dir_q, dir_d;
    logic inr, push, pop, clr;
    logic [SP_W-1:0] sp;
    logic [ENTRY_W-1:0] top;
    maze_stack u_stack (
        .clk(clk), .rst_n(rst_n), .clr(clr), .push(push), .pop(pop),
        .wdata({cx_q, cy_q, dir_q[1:0]}), .sp(sp), .top(top)
    );
    always_comb begin
        inr = dir_q[1:0] == DIR_R ? cx_q != CMAX :
              dir_q[1:0] == DIR_D ? cy_q != CMAX :
              dir_q[1:0] == DIR_L ? cx_q != '0 : cy_q != '0;
        nx  = dir_q[1:0] == DIR_R ? cx_q + 1'b1 : dir_q[1:0] == DIR_L ? cx_q - 1'b1 : cx_q;
        ny  = dir_q[1:0] == DIR_D ? cy_q + 1'b1 : dir_q[1:0] == DIR_U ? cy_q - 1'b1 : cy_q;
    end
    always_comb begin
        state_d = state_q;
        cx_d    = cx_q;
        cy_d    = cy_q;
        dir_d   = dir_q;
        push    = 1'b0;
        pop     = 1'b0;
        clr     = 1'b0;
        RD      = 1'b0;
        WR      = 1'b0;
        X       = '0;
        Y       = '0;
        case (state_q)
            S_IDLE, S_DONE, S_FAIL:
                if (start) begin
                    state_d = S_CHKSTART;
                    cx_d    = COORD_W'(START_X);
                    cy_d    = COORD_W'(START_Y);
                    dir_d   = '0;
                    clr     = 1'b1;
                end
            S_CHKSTART: begin
                RD      = 1'b1;
                X       = cx_q;
                Y       = cy_q;
                state_d = Dout ? S_FAIL : S_MARK;
            end
            S_MARK: begin
                WR      = 1'b1;
                X       = cx_q;
                Y       = cy_q;
                dir_d   = '0;
                state_d = (cx_q == COORD_W'(GOAL_X) && cy_q == COORD_W'(GOAL_Y)) ? S_DONE : S_PROBE;
            end
            S_PROBE:
                if (dir_q[2]) state_d = S_POP;
                else if (!inr) dir_d = dir_q + 1'b1;
                else begin
                    RD = 1'b1;
                    X  = nx;
                    Y  = ny;
                    if (Dout) dir_d = dir_q + 1'b1;
                    // a full stack cannot legally occur; treat it as an unsolvable maze
                    else if (sp == '1) state_d = S_FAIL;
                    else begin
                        push    = 1'b1;
                        cx_d    = nx;
                        cy_d    = ny;
                        state_d = S_MARK;
                    end
                end
            S_POP:
                if (sp == '0) state_d = S_FAIL;
                else begin
                    pop     = 1'b1;
                    cx_d    = top[9:6];
                    cy_d    = top[5:2];
                    dir_d   = {1'b0, top[1:0]} + 3'd1;
                    state_d = S_PROBE;
                end
            default: state_d = S_IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            state_q <= S_IDLE;
            cx_q    <= '0;
            cy_q    <= '0;
            dir_q   <= '0;
        end else begin
            state_q <= state_d;
            cx_q    <= cx_d;
            cy_q    <= cy_d;
            dir_q   <= dir_d;
        end
    assign Din      = WR;
    assign done     = state_q == S_DONE;
    assign fail     = state_q == S_FAIL;
    assign busy     = !(state_q == S_IDLE || done || fail);
    assign path_len = sp;
endmodule

// File: tb/tb_maze_solver.sv
// tb_maze_solver: scoreboard bench for maze_solver against a 16x16 behavioural maze memory
module tb_maze_solver;
    logic clk = 0, rst_n = 0, start = 0;
    logic Dout, RD, WR, Din, busy, done, fail;
    logic [3:0] X, Y;
    logic [7:0] path_len;
    logic mem [16][16];
    typedef struct {bit d; bit f; int len;} exp_t;
    exp_t exp_q[$];
    int total = 0, bad = 0, wr_cnt = 0, both_cnt = 0, pops = 0;
    logic [7:0] prev_len = 0;
    logic prev_busy = 0;

    maze_solver dut (
        .clk(clk), .rst_n(rst_n), .start(start), .Dout(Dout), .X(X), .Y(Y),
        .RD(RD), .WR(WR), .Din(Din), .busy(busy), .done(done), .fail(fail), .path_len(path_len)
    );

    always #5 clk = ~clk;
    assign Dout = RD ? mem[Y][X] : 1'b0;
    always @(posedge clk) if (WR) mem[Y][X] <= Din;
    always @(negedge clk) begin
        if (WR) wr_cnt++;
        if (RD && WR) both_cnt++;
        if (busy && prev_busy && path_len < prev_len) pops++;
        prev_len  = path_len;
        prev_busy = busy;
    end

    task automatic chk(input string tag, input int got, input int exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic fill(input bit v);
        for (int y = 0; y < 16; y++)
            for (int x = 0; x < 16; x++) mem[y][x] = v;
    endtask

    function automatic int ones();
        int n = 0;
        for (int y = 0; y < 16; y++)
            for (int x = 0; x < 16; x++) n += int'(mem[y][x]);
        return n;
    endfunction

    task automatic run(input string tag, input bit ed, input bit ef, input int el,
                       input int ecyc, input bit disturb);
        exp_t e;
        int cyc;
        exp_q.push_back('{ed, ef, el});
        @(negedge clk);
        wr_cnt = 0; both_cnt = 0; pops = 0; start = 1;
        @(negedge clk);
        start = 0;
        cyc = 0;
        while (busy && cyc < 20000) begin
            start = disturb && cyc == 10;
            cyc++;
            @(negedge clk);
        end
        start = 0;
        e = exp_q.pop_front();
        chk({tag, "_timeout"}, int'(cyc < 20000), 1);
        chk({tag, "_done"}, done, e.d);
        chk({tag, "_fail"}, fail, e.f);
        chk({tag, "_len"}, path_len, e.len);
        chk({tag, "_rdwr"}, both_cnt, 0);
        if (ecyc >= 0) chk({tag, "_cyc"}, cyc, ecyc);
    endtask

    initial begin
        int line, n;
        fill(0);
        #12 rst_n = 1;
        @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_fail", fail, 0);
        chk("rst_len", path_len, 0);
        chk("rst_rdwr", {RD, WR}, 0);
        chk("rst_xy", {X, Y}, 0);

        run("open", 1, 0, 30, 77, 0);
        chk("open_marked", ones(), 31);
        line = 0;
        for (int x = 0; x < 16; x++) line += int'(mem[0][x]);
        for (int y = 1; y < 16; y++) line += int'(mem[y][15]);
        chk("open_path", line, 31);
        chk("open_wr", wr_cnt, 31);
        chk("open_pops", pops, 0);

        fill(0);
        mem[0][0] = 1;
        run("blk", 0, 1, 0, 1, 0);
        chk("blk_wr", wr_cnt, 0);

        fill(0);
        mem[15][14] = 1;
        mem[14][15] = 1;
        run("wall", 0, 1, 0, -1, 0);
        chk("wall_marked", ones(), 255);
        chk("wall_goal", mem[15][15], 0);

        fill(0);
        mem[0][6] = 1;
        mem[1][5] = 1;
        run("back", 1, 0, 30, -1, 0);
        chk("back_pop", int'(pops > 0), 1);

        fill(0);
        @(negedge clk);
        start = 1;
        @(negedge clk);
        start = 0;
        n = 0;
        while (!WR && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("rst_seek_mark", WR, 1);
        @(posedge clk);
        #1 chk("rst_probe_rd", RD, 1);
        rst_n = 0;
        #1;
        chk("mid_rst_rd", RD, 0);
        chk("mid_rst_wr", WR, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_xy", {X, Y}, 0);
        chk("mid_rst_len", path_len, 0);
        @(negedge clk);
        rst_n = 1;
        fill(0);
        run("after_rst", 1, 0, 30, 77, 0);

        fill(0);
        run("dist", 1, 0, 30, 77, 1);
        chk("dist_marked", ones(), 31);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
